smaesh_shares_deserializer: RTL

Upstream input stage for the masked AES top. It collects a 32-bit word stream of plaintext shares into one complete 128*d-bit shared block. The block is presented on a valid/ready (SVRS) interface that connects directly to the core's in_data_valid / in_data_ready / in_shares_data. Share encoding on the output is share-major: share i occupies out_shares_data[128*i +: 128].

---
 rtl/smaesh_shares_deserializer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/smaesh_shares_deserializer.sv
// rtl/smaesh_shares_deserializer.sv - packs a 32-bit word stream into one 128*d-bit share-major block
// Optional macro SMAESH_DESER_DOUBLE_BUFFER_EN adds a second bank for back-to-back blocks.
module smaesh_shares_deserializer #(
    parameter int d = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [128*d-1:0]   out_shares_data,
    output logic               err
);
    localparam int NW = 4 * d;
    localparam int CW = $clog2(NW);
    localparam int BW = 128 * d;
    localparam logic [CW-1:0] CNT_LAST = CW'(NW - 1);

    logic [CW-1:0] cnt;
    logic          hs_in;
    logic          at_last;
    logic          blk_done;

    assign hs_in    = in_valid & in_ready;
    assign at_last  = (cnt == CNT_LAST);
    assign blk_done = hs_in & at_last & in_last;

    // Framing: a block ends on the NW-th word and only there; any other pairing drops the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            err <= 1'b0;
            if (hs_in) begin
                if (at_last || in_last) begin
                    cnt <= '0;
                    err <= ~(at_last & in_last);
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

`ifdef SMAESH_DESER_DOUBLE_BUFFER_EN
    logic [BW-1:0] bank [2];
    logic [1:0]    full;
    logic          wptr;
    logic          rptr;

    // wptr always sits on the bank being filled, so it is full only when both banks are.
    assign in_ready        = ~full[wptr] & ~rst;
    assign out_valid       = full[rptr];
    assign out_shares_data = bank[rptr];

    always_ff @(posedge clk) begin
        if (hs_in) begin
            bank[wptr][32*cnt +: 32] <= in_data;
        end
    end

    // Completion targets an empty bank and handout a full one, so both may fire together.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
            wptr <= 1'b0;
            rptr <= 1'b0;
        end else begin
            if (blk_done) begin
                full[wptr] <= 1'b1;
                wptr       <= ~wptr;
            end
            if (out_valid && out_ready) begin
                full[rptr] <= 1'b0;
                rptr       <= ~rptr;
            end
        end
    end
`else
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t        state;
    logic [BW-1:0] data_q;

    assign in_ready        = (state == FILL) & ~rst;
    assign out_shares_data = data_q;

    always_ff @(posedge clk) begin
        if (hs_in) begin
            data_q[32*cnt +: 32] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            out_valid <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (blk_done) begin
                        state     <= FULL;
                        out_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= FILL;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule
